multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH / DECODE / EXEC / MEM states and drives datapath control strobes per state.
- Handshakes with instruction/data memory via mem_ready, bounded by a timeout.
- Counts retired instructions and reports halt/fault to the top-level testbench.

Parameters:
OPCODE_W, 8, opcode width
ALUOP_W, 3, alu_op width; alu_op = opcode[ALUOP_W-1:0]
CNT_W, 16, retired-instruction counter width
MEM_TIMEOUT, 15, max wait cycles for mem_ready before fault (>=1)
OP_LOAD, 8'h01, load opcode
OP_STORE, 8'h02, store opcode
OP_JUMP, 8'h03, unconditional jump opcode
OP_BRZ, 8'h04, branch-if-zero opcode
OP_HALT, 8'hFF, halt opcode

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin execution from IDLE
opcode  in  OPCODE_W  opcode field of instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current request this cycle
ir_write  out  1  load instruction register
pc_write  out  1  update PC
jump  out  1  PC source = jump target
branch  out  1  PC source = branch target
mem_read  out  1  memory read request (fetch or load)
mem_write  out  1  memory write request
reg_write  out  1  register file write enable
alu_op  out  ALUOP_W  ALU operation select
done  out  1  halted
fault  out  1  memory timeout occurred (sticky)
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- One clock; reset is synchronous and active-high. Ports are clk and reset.
- Reset, including mid-instruction: state <= IDLE, wait counter <= 0, instr_count <= 0. All strobes, done and fault are 0 in IDLE.
- Outputs are combinational from current state, opcode, zero and mem_ready. A strobe asserts in the same cycle as its condition.
- Any output not listed for a state is 0.
- alu_op = opcode[ALUOP_W-1:0] in EXEC only; otherwise 0.
- IDLE: start=1 -> FETCH next cycle. Otherwise stay.
- FETCH: mem_read=1.
  - mem_ready=1 -> ir_write=1, go DECODE.
  - Otherwise wait.
- DECODE: one cycle.
  - OP_HALT -> HALTED.
  - OP_JUMP -> jump=1, pc_write=1, retire, go FETCH.
  - OP_BRZ -> branch=1, pc_write=zero, retire, go FETCH. When zero=0 the PC increment is the datapath default and pc_write stays 0.
  - OP_LOAD / OP_STORE -> MEM.
  - Any other opcode -> EXEC.
- EXEC: one cycle. reg_write=1, pc_write=1, retire, go FETCH.
- MEM load: mem_read=1 until mem_ready. On the mem_ready cycle: reg_write=1, pc_write=1, retire, go FETCH.
- MEM store: mem_write=1 until mem_ready. On the mem_ready cycle: pc_write=1, retire, go FETCH.
- Wait counter:
  - Clears on entry to FETCH or MEM.
  - Increments each cycle those states are occupied with mem_ready=0.
  - If it reaches MEM_TIMEOUT with mem_ready still 0 -> FAULT next cycle.
  - mem_ready=1 on the MEM_TIMEOUT-th wait cycle still completes normally.
- HALTED: done=1. FAULT: fault=1. Both absorbing until reset; start is ignored in both.
- start outside IDLE is ignored.
- Retire: instr_count+1 on the cycle the instruction's final strobe is issued; HALT does not retire. Saturates at 2^CNT_W-1, no wrap.
- mem_read and mem_write are never both 1. Requests hold stable until mem_ready.

Test Plan:
- Reset, then start=1 with opcode=8'h10 and mem_ready always 1:
  - FETCH, DECODE, EXEC take 3 cycles.
  - alu_op=3'b000 and reg_write=1 in EXEC.
  - instr_count=1.
- LOAD (8'h01), mem_ready delayed 3 cycles in MEM:
  - mem_read held 4 cycles.
  - reg_write and pc_write pulse once on the ready cycle; instr_count +1.
- BRZ (8'h04):
  - zero=1 -> branch=1, pc_write=1 in DECODE.
  - zero=0 -> branch=1, pc_write=0.
  - Both retire.
- Fetch with mem_ready held 0 and MEM_TIMEOUT=15:
  - fault=1 after 15 wait cycles and stays 1.
  - start is ignored.
  - reset returns to IDLE with fault=0.
- HALT (8'hFF) after 2 ALU ops: done=1, instr_count=2, no further strobes.
- CNT_W=2 with 5 ALU instructions: instr_count saturates at 3.
- Reset asserted mid-MEM store: next cycle mem_write=0, state IDLE, instr_count=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer; strobes are combinational from state, opcode, zero and mem_ready.
// Memory requests hold until mem_ready; a request unanswered for MEM_TIMEOUT cycles latches a sticky fault.
module multicycle_control_unit #(
    parameter int                  OPCODE_W    = 8,
    parameter int                  ALUOP_W     = 3,
    parameter int                  CNT_W       = 16,
    parameter int                  MEM_TIMEOUT = 15,
    parameter logic [OPCODE_W-1:0] OP_LOAD     = 8'h01,
    parameter logic [OPCODE_W-1:0] OP_STORE    = 8'h02,
    parameter logic [OPCODE_W-1:0] OP_JUMP     = 8'h03,
    parameter logic [OPCODE_W-1:0] OP_BRZ      = 8'h04,
    parameter logic [OPCODE_W-1:0] OP_HALT     = 8'hFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                jump,
    output logic                branch,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                done,
    output logic                fault,
    output logic [CNT_W-1:0]    instr_count
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALTED, S_FAULT
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_count;

    logic w_is_load, w_is_store, w_is_jump, w_is_brz, w_is_halt;
    logic w_retire, w_timeout;

    assign w_is_load  = (opcode == OP_LOAD);
    assign w_is_store = (opcode == OP_STORE);
    assign w_is_jump  = (opcode == OP_JUMP);
    assign w_is_brz   = (opcode == OP_BRZ);
    assign w_is_halt  = (opcode == OP_HALT);

    // Final-strobe cycle of every instruction except HALT.
    assign w_retire = ((r_state == S_DECODE) && !w_is_halt && (w_is_jump || w_is_brz))
                   || (r_state == S_EXEC)
                   || ((r_state == S_MEM) && mem_ready);

    // True on the MEM_TIMEOUT-th consecutive cycle without mem_ready.
    assign w_timeout = !mem_ready && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

    assign instr_count = r_count;

    always_comb begin
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        jump      = 1'b0;
        branch    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        alu_op    = '0;
        done      = 1'b0;
        fault     = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
            end
            S_DECODE: begin
                if (!w_is_halt && w_is_jump) begin
                    jump     = 1'b1;
                    pc_write = 1'b1;
                end else if (!w_is_halt && w_is_brz) begin
                    branch   = 1'b1;
                    pc_write = zero;
                end
            end
            S_EXEC: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                alu_op    = opcode[ALUOP_W-1:0];
            end
            S_MEM: begin
                if (w_is_load) begin
                    mem_read  = 1'b1;
                    reg_write = mem_ready;
                end else begin
                    mem_write = 1'b1;
                end
                pc_write = mem_ready;
            end
            S_HALTED: done  = 1'b1;
            S_FAULT:  fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            if (w_retire && (r_count != {CNT_W{1'b1}}))
                r_count <= r_count + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_wait  <= '0;
                    end
                end
                S_FETCH, S_MEM: begin
                    if (mem_ready) begin
                        r_state <= (r_state == S_FETCH) ? S_DECODE : S_FETCH;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_is_halt) begin
                        r_state <= S_HALTED;
                    end else if (w_is_jump || w_is_brz) begin
                        r_state <= S_FETCH;
                        r_wait  <= '0;
                    end else if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                        r_wait  <= '0;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
                S_HALTED, S_FAULT: r_state <= r_state;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
